// File: rtl/lane_stream_pkg.sv
// -----------------------------------------------------------------------------
// lane_stream_pkg
// Shared types and constants for the lane stream merger.
//   LANE_BYTE_W   : payload width of one lane beat
//   LANE_IDX_W    : width of the internal lane tag (covers up to 8 lanes)
//   merge_state_e : frame FSM states (RUN accepts input, DRAIN waits for the
//                   frame-final byte to leave)
//   lane_beat_t   : contents of the output register {idx, data, last}
// -----------------------------------------------------------------------------
package lane_stream_pkg;

  localparam int LANE_BYTE_W = 8;
  localparam int LANE_IDX_W  = 3;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } merge_state_e;

  // "byte" is a keyword, so the payload field is called data.
  typedef struct packed {
    logic [LANE_IDX_W-1:0]  idx;
    logic [LANE_BYTE_W-1:0] data;
    logic                   last;
  } lane_beat_t;

endpackage

// File: rtl/lane_stream_merge_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first requesting bit at or after ptr_i,
// wrapping around. N must be a power of two so the index wraps by overflow.
// Ports:
//   req_i         : request vector
//   ptr_i         : index searched first
//   grant_valid_o : some request was found
//   grant_oh_o    : one-hot grant (zero when nothing requests)
//   grant_idx_o   : index of the granted bit (zero when nothing requests)
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int N  = 8,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic          grant_valid_o,
  output logic [N-1:0]  grant_oh_o,
  output logic [PW-1:0] grant_idx_o
);

  always_comb begin
    logic [PW-1:0] cand;
    grant_valid_o = 1'b0;
    grant_idx_o   = '0;
    cand          = '0;
    for (int i = 0; i < N; i++) begin
      cand = ptr_i + PW'(i);
      if (!grant_valid_o && req_i[cand]) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = cand;
      end
    end
    grant_oh_o = grant_valid_o ? (N'(1) << grant_idx_o) : '0;
  end

endmodule

// File: rtl/lane_stream_merge.sv
// -----------------------------------------------------------------------------
// lane_stream_merge
// Merges LANES per-lane byte streams into one idx-tagged byte stream. Lanes are
// served round-robin, one byte per cycle, through a single pass-through output
// register. A frame closes once every lane has delivered its last byte; the
// frame-final byte is flagged with out_bits_last and its output handshake
// pulses status_done and restarts the search at lane 0.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : per-lane handshake (at most one in_ready bit high)
//   in_byte, in_last    : lane k payload at [8k+7:8k], lane k final byte
//   out_valid/out_ready : merged stream handshake
//   out_bits_idx/_byte/_last : source lane, byte, frame-final flag
//   status_done         : one-cycle pulse after the frame-final handshake
//
// Optional feature, enabled by defining LANE_STREAM_MERGE_STATS_EN:
//   stat_frames[15:0]   : completed frames, wrapping
//   stat_bytes[31:0]    : output handshakes, saturating, restarted at frame start
// -----------------------------------------------------------------------------
module lane_stream_merge
  import lane_stream_pkg::*;
#(
  parameter int LANES = 8,
  parameter int IDX_W = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [LANES-1:0]               in_valid,
  output logic [LANES-1:0]               in_ready,
  input  logic [LANES*LANE_BYTE_W-1:0]   in_byte,
  input  logic [LANES-1:0]               in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [IDX_W-1:0]               out_bits_idx,
  output logic [LANE_BYTE_W-1:0]         out_bits_byte,
  output logic                           out_bits_last,
  output logic                           status_done
`ifdef LANE_STREAM_MERGE_STATS_EN
  ,
  output logic [15:0]                    stat_frames,
  output logic [31:0]                    stat_bytes
`endif
);

  localparam int PW = $clog2(LANES);

  merge_state_e     state_q, state_d;
  logic [LANES-1:0] done_mask_q, done_mask_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  lane_beat_t       beat_q, beat_d;
  logic             out_valid_q, out_valid_d;
  logic             status_done_q;
  // Low for the first cycle after reset so in_ready is held off while rst_n
  // is asserted and the first grant is taken from a clean state.
  logic             active_q;

  logic             grant_valid;
  logic [LANES-1:0] grant_oh;
  logic [PW-1:0]    grant_idx;
  logic [LANE_BYTE_W-1:0] lane_byte;
  logic             lane_last;
  logic             last_frame;
  logic             in_hs;
  logic             out_hs;
  logic             frame_end;

  // Lanes that already closed this frame are masked out of arbitration.
  rr_arbiter #(.N(LANES)) u_arb (
    .req_i         (in_valid & ~done_mask_q),
    .ptr_i         (rr_ptr_q),
    .grant_valid_o (grant_valid),
    .grant_oh_o    (grant_oh),
    .grant_idx_o   (grant_idx)
  );

  assign lane_byte  = in_byte[grant_idx*LANE_BYTE_W +: LANE_BYTE_W];
  assign lane_last  = in_last[grant_idx];
  // Frame-final when this is the granted lane's last byte and every other
  // lane has already closed.
  assign last_frame = lane_last & (&(done_mask_q | grant_oh));

  // The output slot is free when empty or emptying this cycle, which makes
  // in_ready combinational from out_ready.
  assign in_hs     = grant_valid & (~out_valid_q | out_ready) & (state_q == RUN) & active_q;
  assign out_hs    = out_valid_q & out_ready;
  assign frame_end = (state_q == DRAIN) & out_hs;

  assign in_ready = in_hs ? grant_oh : '0;

  always_comb begin
    state_d     = state_q;
    done_mask_d = done_mask_q;
    rr_ptr_d    = rr_ptr_q;
    beat_d      = beat_q;
    out_valid_d = out_valid_q;

    if (out_hs) begin
      out_valid_d = 1'b0;
    end
    // A new grant in the same cycle as an output handshake reloads with no bubble.
    if (in_hs) begin
      out_valid_d = 1'b1;
      beat_d.idx  = LANE_IDX_W'(grant_idx);
      beat_d.data = lane_byte;
      beat_d.last = last_frame;
      rr_ptr_d    = grant_idx + PW'(1);
      if (lane_last) begin
        done_mask_d = done_mask_q | grant_oh;
      end
    end

    case (state_q)
      RUN: begin
        if (in_hs && last_frame) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_hs) begin
          state_d     = RUN;
          done_mask_d = '0;
          rr_ptr_d    = '0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      done_mask_q   <= '0;
      rr_ptr_q      <= '0;
      beat_q        <= '0;
      out_valid_q   <= 1'b0;
      status_done_q <= 1'b0;
      active_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      done_mask_q   <= done_mask_d;
      rr_ptr_q      <= rr_ptr_d;
      beat_q        <= beat_d;
      out_valid_q   <= out_valid_d;
      status_done_q <= frame_end;
      active_q      <= 1'b1;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_bits_idx  = IDX_W'(beat_q.idx);
  assign out_bits_byte = beat_q.data;
  assign out_bits_last = beat_q.last;
  assign status_done   = status_done_q;

`ifdef LANE_STREAM_MERGE_STATS_EN
  logic [15:0] stat_frames_q;
  logic [31:0] stat_bytes_q, stat_bytes_d;

  // The handshake that closes a frame also opens the next count window, so
  // the restart value is 1 rather than 0: every handshake is counted once.
  always_comb begin
    stat_bytes_d = stat_bytes_q;
    if (frame_end) begin
      stat_bytes_d = 32'd1;
    end else if (out_hs && (stat_bytes_q != 32'hFFFF_FFFF)) begin
      stat_bytes_d = stat_bytes_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_frames_q <= '0;
      stat_bytes_q  <= '0;
    end else begin
      stat_bytes_q <= stat_bytes_d;
      if (frame_end) begin
        stat_frames_q <= stat_frames_q + 16'd1;
      end
    end
  end

  assign stat_frames = stat_frames_q;
  assign stat_bytes  = stat_bytes_q;
`endif

endmodule

// File: tb/tb_lane_stream_merge.sv
module tb_lane_stream_merge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_valid;
  logic [7:0]  in_ready;
  logic [63:0] in_byte;
  logic [7:0]  in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_bits_idx;
  logic [7:0]  out_bits_byte;
  logic        out_bits_last;
  logic        status_done;
`ifdef LANE_STREAM_MERGE_STATS_EN
  logic [15:0] stat_frames;
  logic [31:0] stat_bytes;
`endif

  always #5 clk = ~clk;

  lane_stream_merge #(.LANES(8), .IDX_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_byte       (in_byte),
    .in_last       (in_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_bits_idx  (out_bits_idx),
    .out_bits_byte (out_bits_byte),
    .out_bits_last (out_bits_last),
    .status_done   (status_done)
`ifdef LANE_STREAM_MERGE_STATS_EN
    ,
    .stat_frames   (stat_frames),
    .stat_bytes    (stat_bytes)
`endif
  );

  int checks = 0;
  int errors = 0;
  int beats  = 0;

  // Scoreboard entries: {idx[7:0], byte[7:0], last}
  logic [16:0] exp_q[$];

  // Per-lane stimulus queues: {last, byte}
  logic [8:0] lane_mem [8][32];
  int         head [8];
  int         tail [8];

  int   mode;       // 0: out_ready=1, 1: toggle, 2: stall frame-final byte
  int   stall_cnt;
  logic stalled;
  logic hold;
  logic [7:0] hs_prev;

  logic        mon_prev_stall;
  logic        mon_prev_final;
  logic [16:0] mon_prev_bits;
  logic [16:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic load(input int k, input logic [7:0] b, input logic l);
    lane_mem[k][tail[k]] = {l, b};
    tail[k]++;
  endtask

  task automatic push_exp(input int idx, input logic [7:0] b, input logic l);
    exp_q.push_back({idx[7:0], b, l});
  endtask

  function automatic bit lanes_empty();
    for (int k = 0; k < 8; k++) if (head[k] < tail[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      if (lanes_empty() && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: got %0d beats pending required 0", name, exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Lane driver: presents queue heads, records handshakes half a cycle
  // before the edge and pops them on the following falling edge.
  initial begin
    in_valid = '0; in_byte = '0; in_last = '0; out_ready = 1'b1;
    hs_prev = '0; stalled = 1'b0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 8; k++) if (hs_prev[k]) head[k]++;
      stalled = 1'b0;
      case (mode)
        1: out_ready = ~out_ready;
        2: begin
          if (out_valid && out_bits_last && stall_cnt < 5) begin
            out_ready = 1'b0;
            stall_cnt++;
            stalled = 1'b1;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'b1;
      endcase
      for (int k = 0; k < 8; k++) begin
        if (!hold && head[k] < tail[k]) begin
          in_valid[k]       = 1'b1;
          in_byte[k*8 +: 8] = lane_mem[k][head[k]][7:0];
          in_last[k]        = lane_mem[k][head[k]][8];
        end else begin
          in_valid[k]       = 1'b0;
          in_byte[k*8 +: 8] = 8'h00;
          in_last[k]        = 1'b0;
        end
      end
      #1;
      if (rst_n) begin
        hs_prev = in_ready & in_valid;
        chk("in_ready_onehot0", 32'($onehot0(in_ready)), 32'd1);
        chk("in_ready_without_valid", 32'(in_ready & ~in_valid), 32'd0);
        if (stalled) chk("drain_in_ready", 32'(in_ready), 32'd0);
      end else begin
        hs_prev = '0;
      end
    end
  end

  // Monitor: pops the scoreboard on every output handshake, checks payload
  // stability across stalls and the status_done pulse timing.
  initial begin
    mon_prev_stall = 1'b0;
    mon_prev_final = 1'b0;
    mon_prev_bits  = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        mon_prev_stall = 1'b0;
        mon_prev_final = 1'b0;
      end else begin
        chk("status_done", 32'(status_done), 32'(mon_prev_final));
        if (mon_prev_stall)
          chk("stall_hold", 32'({out_valid, out_bits_idx, out_bits_byte, out_bits_last}),
              32'({1'b1, mon_prev_bits}));
        mon_prev_final = 1'b0;
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got idx=%0d byte=%02h required no beat",
                     out_bits_idx, out_bits_byte);
          end else begin
            mon_exp = exp_q.pop_front();
            checks--;
            chk("beat", 32'({out_bits_idx, out_bits_byte, out_bits_last}), 32'(mon_exp));
            $display("beat %0d: idx=%0d byte=%02h last=%0d", beats, out_bits_idx,
                     out_bits_byte, out_bits_last);
          end
          beats++;
          mon_prev_final = out_bits_last;
        end
        mon_prev_stall = out_valid && !out_ready;
        mon_prev_bits  = {out_bits_idx, out_bits_byte, out_bits_last};
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish required finish before 200000");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "global timeout");
  end

  initial begin
    int b0;
    bit found;
    for (int k = 0; k < 8; k++) begin head[k] = 0; tail[k] = 0; end
    mode = 0; stall_cnt = 5; hold = 1'b0;
    rst_n = 1'b0;

    // Test 1 stimulus is queued while reset is held: in_ready must stay low.
    for (int k = 0; k < 8; k++) begin
      load(k, 8'h10 + 8'(k), 1'b1);
      push_exp(k, 8'h10 + 8'(k), k == 7);
    end
    #22;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_bits", 32'({out_bits_idx, out_bits_byte, out_bits_last}), 32'd0);
    chk("rst_status_done", 32'(status_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_drain("t1_one_byte_per_lane");

    // Test 2: lane 2 sends three bytes; every lane already has its next-frame
    // byte queued, so closed lanes stay valid but must not be granted.
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin
        load(2, 8'hA0, 1'b0); load(2, 8'hA1, 1'b0); load(2, 8'hA2, 1'b1);
      end else begin
        load(k, 8'h20 + 8'(k), 1'b1);
      end
      load(k, 8'hB0 + 8'(k), 1'b1);
    end
    push_exp(0, 8'h20, 0); push_exp(1, 8'h21, 0); push_exp(2, 8'hA0, 0);
    push_exp(3, 8'h23, 0); push_exp(4, 8'h24, 0); push_exp(5, 8'h25, 0);
    push_exp(6, 8'h26, 0); push_exp(7, 8'h27, 0); push_exp(2, 8'hA1, 0);
    push_exp(2, 8'hA2, 1);
    for (int k = 0; k < 8; k++) push_exp(k, 8'hB0 + 8'(k), k == 7);
    wait_drain("t2_lane2_interleave");

    // Test 3: out_ready toggles every cycle.
    mode = 1;
    for (int k = 0; k < 8; k++) begin
      load(k, 8'h60 + 8'(k), 1'b1);
      push_exp(k, 8'h60 + 8'(k), k == 7);
    end
    wait_drain("t3_toggle_ready");
    mode = 0;

    // Test 4: frame-final byte held for 5 cycles; next frame already queued.
    stall_cnt = 0;
    mode = 2;
    for (int k = 0; k < 8; k++) begin
      load(k, 8'h70 + 8'(k), 1'b1);
      load(k, 8'h80 + 8'(k), 1'b1);
    end
    for (int k = 0; k < 8; k++) push_exp(k, 8'h70 + 8'(k), k == 7);
    for (int k = 0; k < 8; k++) push_exp(k, 8'h80 + 8'(k), k == 7);
    wait_drain("t4_final_stall");
    chk("t4_stall_cycles", 32'(stall_cnt), 32'd5);
    mode = 0;

    // Test 5: asynchronous reset after three output bytes of a frame.
    for (int k = 0; k < 8; k++) begin
      load(k, 8'h90 + 8'(k), 1'b1);
      push_exp(k, 8'h90 + 8'(k), k == 7);
    end
    b0 = beats;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      if (beats >= b0 + 3) begin found = 1'b1; break; end
    end
    chk("t5_three_beats_seen", 32'(found), 32'd1);
    #1 hold = 1'b1;
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_out_bits", 32'({out_bits_idx, out_bits_byte, out_bits_last}), 32'd0);
    chk("t5_rst_in_ready", 32'(in_ready), 32'd0);
    chk("t5_rst_status_done", 32'(status_done), 32'd0);
    exp_q.delete();
    for (int k = 0; k < 8; k++) begin head[k] = 0; tail[k] = 0; end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) begin
      load(k, 8'hC0 + 8'(k), 1'b1);
      push_exp(k, 8'hC0 + 8'(k), k == 7);
    end
    hold = 1'b0;
    wait_drain("t5_after_reset");

`ifdef LANE_STREAM_MERGE_STATS_EN
    // Second frame since reset, final byte stalled to observe DRAIN.
    stall_cnt = 0;
    mode = 2;
    for (int k = 0; k < 8; k++) begin
      load(k, 8'hD0 + 8'(k), 1'b1);
      push_exp(k, 8'hD0 + 8'(k), k == 7);
    end
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      #2;
      if (out_valid && out_bits_last && !out_ready) begin found = 1'b1; break; end
    end
    chk("t6_drain_seen", 32'(found), 32'd1);
    chk("t6_stat_bytes_drain", stat_bytes, 32'd8);
    chk("t6_stat_frames_drain", 32'(stat_frames), 32'd1);
    wait_drain("t6_stats");
    chk("t6_stat_frames_end", 32'(stat_frames), 32'd2);
    mode = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
